// File: rtl/fc_argmax_classifier.sv
// Final classification stage: captures the FC scores, scans them serially
// for the maximum, and reports the winning class index and score.
module fc_argmax_classifier #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned NUMBER_OF_CLASSES = 10,
  parameter int unsigned ARITH_TYPE        = 0,
  parameter int unsigned INDEX_WIDTH       = $clog2(NUMBER_OF_CLASSES),
  parameter int unsigned COUNT_WIDTH       = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start_from_previous,
  input  logic [NUMBER_OF_CLASSES*DATA_WIDTH-1:0] data_in,
  output logic                                    end_to_previous,
  output logic                                    busy,
  output logic [INDEX_WIDTH-1:0]                  class_index,
  output logic [DATA_WIDTH-1:0]                   class_score,
  output logic                                    output_ready,
  output logic [COUNT_WIDTH-1:0]                  inference_count
);

  localparam int unsigned LAST = NUMBER_OF_CLASSES - 1;
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Maps a score onto an unsigned-ordered key (float sign-magnitude or two's complement).
  function automatic logic [DATA_WIDTH-1:0] cmp_key(input logic [DATA_WIDTH-1:0] x);
    if (ARITH_TYPE == 0 && x[DATA_WIDTH-1]) return ~x;
    return x ^ MSB_MASK;
  endfunction

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  score_buf [NUMBER_OF_CLASSES];
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0]  best_q, best_d;
  logic [DATA_WIDTH-1:0]  cand;
  logic                   greater;
  logic                   capture;
  logic                   end_d, busy_d, ready_d;
  logic [INDEX_WIDTH-1:0] class_index_d;
  logic [DATA_WIDTH-1:0]  class_score_d;
  logic [COUNT_WIDTH-1:0] count_d;

  assign cand    = score_buf[cnt_q];
  assign greater = cmp_key(cand) > cmp_key(best_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    capture       = 1'b0;
    end_d         = 1'b0;
    ready_d       = 1'b0;
    class_index_d = class_index;
    class_score_d = class_score;
    count_d       = inference_count;
    case (state_q)
      IDLE: begin
        if (start_from_previous) begin
          capture    = 1'b1;
          best_d     = data_in[DATA_WIDTH-1:0];
          best_idx_d = '0;
          cnt_d      = INDEX_WIDTH'(1);
          end_d      = 1'b1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (greater) begin
          best_d     = cand;
          best_idx_d = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        // Last compare: publish the winner so it is visible during DONE.
        if (cnt_q == INDEX_WIDTH'(LAST)) begin
          cnt_d         = '0;
          class_index_d = greater ? cnt_q : best_idx_q;
          class_score_d = greater ? cand : best_q;
          ready_d       = 1'b1;
          count_d       = inference_count + 1'b1;
          state_d       = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      best_q          <= '0;
      best_idx_q      <= '0;
      end_to_previous <= 1'b0;
      busy            <= 1'b0;
      class_index     <= '0;
      class_score     <= '0;
      output_ready    <= 1'b0;
      inference_count <= '0;
      for (int k = 0; k < int'(NUMBER_OF_CLASSES); k++) score_buf[k] <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      best_q          <= best_d;
      best_idx_q      <= best_idx_d;
      end_to_previous <= end_d;
      busy            <= busy_d;
      class_index     <= class_index_d;
      class_score     <= class_score_d;
      output_ready    <= ready_d;
      inference_count <= count_d;
      if (capture) begin
        for (int k = 0; k < int'(NUMBER_OF_CLASSES); k++)
          score_buf[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench for fc_argmax_classifier: a fixed-point instance (2-bit count)
// and a float instance share the same stimulus.
module tb_fc_argmax_classifier;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [NC*DW-1:0] data_in;
  logic [DW-1:0]   sc [NC];

  logic            fx_end, fx_busy, fx_ready;
  logic [3:0]      fx_idx;
  logic [DW-1:0]   fx_score;
  logic [1:0]      fx_count;
  logic            fl_end, fl_busy, fl_ready;
  logic [3:0]      fl_idx;
  logic [DW-1:0]   fl_score;
  logic [7:0]      fl_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_argmax_classifier #(.ARITH_TYPE(1), .COUNT_WIDTH(2)) dut_fx (
    .clk(clk), .reset(reset), .start_from_previous(start), .data_in(data_in),
    .end_to_previous(fx_end), .busy(fx_busy), .class_index(fx_idx),
    .class_score(fx_score), .output_ready(fx_ready), .inference_count(fx_count)
  );

  fc_argmax_classifier #(.ARITH_TYPE(0), .COUNT_WIDTH(8)) dut_fl (
    .clk(clk), .reset(reset), .start_from_previous(start), .data_in(data_in),
    .end_to_previous(fl_end), .busy(fl_busy), .class_index(fl_idx),
    .class_score(fl_score), .output_ready(fl_ready), .inference_count(fl_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int k = 0; k < int'(NC); k++) data_in[k*DW +: DW] = sc[k];
  endtask

  task automatic scramble_data();
    for (int k = 0; k < int'(NC); k++) data_in[k*DW +: DW] = $urandom;
  endtask

  task automatic set_fixed_a();
    int v [10] = '{3, 7, -2, 9, 0, 1, 9, 4, -5, 2};
    for (int k = 0; k < int'(NC); k++) sc[k] = v[k];
  endtask

  // One inference from cycle 0; checks pulses on cycles 1..11 and the result on cycle 10.
  task automatic run_one(input string nm, input bit use_fl, input bit scr,
                         input int exp_idx, input logic [31:0] exp_score);
    logic [3:0]  idx;
    logic [31:0] scv;
    load();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      idx = use_fl ? fl_idx : fx_idx;
      scv = use_fl ? fl_score : fx_score;
      checks++;
      if (fx_end !== (c == 1)) begin
        errors++;
        $display("FAIL %s end_to_previous cycle %0d got %b exp %b", nm, c, fx_end, (c == 1));
      end
      checks++;
      if (fx_ready !== (c == 10) || fl_ready !== (c == 10)) begin
        errors++;
        $display("FAIL %s output_ready cycle %0d got %b/%b exp %b", nm, c, fx_ready, fl_ready, (c == 10));
      end
      checks++;
      if (fx_busy !== (c <= 10)) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b exp %b", nm, c, fx_busy, (c <= 10));
      end
      if (c == 10) begin
        checks++;
        if (idx !== 4'(exp_idx)) begin
          errors++;
          $display("FAIL %s class_index got %0d exp %0d", nm, idx, exp_idx);
        end
        checks++;
        if (scv !== exp_score) begin
          errors++;
          $display("FAIL %s class_score got %h exp %h", nm, scv, exp_score);
        end
      end
      if (scr) scramble_data();
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    data_in = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({fx_end, fx_busy, fx_ready, fx_idx, fx_score, fx_count} !== '0) begin
      errors++;
      $display("FAIL reset_fx outputs got end=%b busy=%b rdy=%b idx=%0d score=%h cnt=%0d exp all 0",
               fx_end, fx_busy, fx_ready, fx_idx, fx_score, fx_count);
    end
    checks++;
    if ({fl_end, fl_busy, fl_ready, fl_idx, fl_score, fl_count} !== '0) begin
      errors++;
      $display("FAIL reset_fl outputs got end=%b busy=%b rdy=%b idx=%0d score=%h cnt=%0d exp all 0",
               fl_end, fl_busy, fl_ready, fl_idx, fl_score, fl_count);
    end
  endtask

  task automatic test_fixed();
    set_fixed_a();
    run_one("fixed_a", 1'b0, 1'b0, 3, 32'd9);
    set_fixed_a();
    run_one("fixed_a_scrambled", 1'b0, 1'b1, 3, 32'd9);
    for (int k = 0; k < int'(NC); k++) sc[k] = 32'd5;
    run_one("fixed_ties", 1'b0, 1'b0, 0, 32'd5);
    for (int k = 0; k < int'(NC); k++) sc[k] = -100;
    sc[9] = 32'hFFFF_FFFF;
    run_one("fixed_last", 1'b0, 1'b0, 9, 32'hFFFF_FFFF);
  endtask

  task automatic test_float();
    for (int k = 0; k < int'(NC); k++) sc[k] = 32'hC000_0000;
    sc[0] = 32'hBF80_0000;
    sc[1] = 32'hBF00_0000;
    sc[2] = 32'hC040_0000;
    run_one("float_neg", 1'b1, 1'b0, 1, 32'hBF00_0000);
    for (int k = 0; k < int'(NC); k++) sc[k] = 32'hBF80_0000;
    sc[0] = 32'h8000_0000;
    sc[1] = 32'h0000_0000;
    run_one("float_zero", 1'b1, 1'b0, 1, 32'h0000_0000);
  endtask

  // Start held for cycles 0..14; data switches to all-5 after cycle 0.
  task automatic test_hold_start();
    set_fixed_a();
    load();
    for (int c = 0; c <= 22; c++) begin
      checks++;
      if (fx_end !== (c == 1 || c == 12)) begin
        errors++;
        $display("FAIL hold end_to_previous cycle %0d got %b exp %b", c, fx_end, (c == 1 || c == 12));
      end
      checks++;
      if (fx_ready !== (c == 10 || c == 21)) begin
        errors++;
        $display("FAIL hold output_ready cycle %0d got %b exp %b", c, fx_ready, (c == 10 || c == 21));
      end
      if (c == 10) begin
        checks++;
        if (fx_idx !== 4'd3 || fx_score !== 32'd9) begin
          errors++;
          $display("FAIL hold first_result got %0d/%h exp 3/00000009", fx_idx, fx_score);
        end
      end
      if (c == 21) begin
        checks++;
        if (fx_idx !== 4'd0 || fx_score !== 32'd5) begin
          errors++;
          $display("FAIL hold second_result got %0d/%h exp 0/00000005", fx_idx, fx_score);
        end
      end
      start = (c <= 14);
      if (c == 1) begin
        for (int k = 0; k < int'(NC); k++) sc[k] = 32'd5;
        load();
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_fixed_a();
    load();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({fx_end, fx_busy, fx_ready, fx_idx, fx_score, fx_count} !== '0 ||
        {fl_end, fl_busy, fl_ready, fl_idx, fl_score, fl_count} !== '0) begin
      errors++;
      $display("FAIL mid_reset outputs got fx idx=%0d score=%h cnt=%0d busy=%b fl idx=%0d score=%h cnt=%0d busy=%b exp all 0",
               fx_idx, fx_score, fx_count, fx_busy, fl_idx, fl_score, fl_count, fl_busy);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (fx_ready !== 1'b0 || fx_busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset aborted cycle %0d got rdy=%b busy=%b exp 0/0", c, fx_ready, fx_busy);
      end
      tick();
    end
    set_fixed_a();
    run_one("after_reset", 1'b0, 1'b0, 3, 32'd9);
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < int'(NC); k++) sc[k] = 32'(i * 7 + k);
      run_one("count_run", 1'b0, 1'b0, 9, 32'(i * 7 + 9));
      checks++;
      if (fx_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL count_wrap run %0d got %0d exp %0d", i, fx_count, exp_cnt[i]);
      end
    end
    checks++;
    if (fl_count !== 8'd5) begin
      errors++;
      $display("FAIL count_8bit got %0d exp 5", fl_count);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_float();
    test_hold_start();
    test_mid_reset();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
